// File: rtl/regfile_dump_reader.sv
`timescale 1ns/1ps
// Walks the register file through its async read port and streams {addr, data, last} beats, then pulses DONE.
// Latency: START edge -> first beat valid two cycles later; one beat per two cycles with OUT_READY held high.
// Backpressure: OUT_READY low parks the beat in SEND with every output frozen. Build option REGDUMP_SKIP_ZERO_EN skips register 0.
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [ADDR_WIDTH-1:0] RA,
    input  logic [DATA_WIDTH-1:0] RD,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [ADDR_WIDTH-1:0] OUT_ADDR,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_LAST
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
`ifdef REGDUMP_SKIP_ZERO_EN
    // Register 0 is hardwired zero, so the dump starts at 1.
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
`else
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = '0;
`endif

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
        logic                  last;
    } beat_t;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    beat_t                 beat_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  out_hsk;

    assign out_hsk = (state_q == ST_SEND) && OUT_READY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    cnt_d   = FIRST_ADDR;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_hsk) begin
                    if (beat_q.last) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Each word is sampled in its own FETCH cycle, so later writes to unfetched entries show up.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beat_q <= '0;
        end else if (state_q == ST_FETCH) begin
            beat_q.addr <= cnt_q;
            beat_q.dat  <= RD;
            beat_q.last <= (cnt_q == LAST_ADDR);
        end
    end

    // BUSY rises together with the first valid beat and drops in the DONE cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= out_hsk && beat_q.last;
            if (out_hsk && beat_q.last) begin
                busy_q <= 1'b0;
            end else if (state_q == ST_FETCH) begin
                busy_q <= 1'b1;
            end
        end
    end

    assign RA        = cnt_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign OUT_VALID = (state_q == ST_SEND);
    assign OUT_ADDR  = beat_q.addr;
    assign OUT_DATA  = beat_q.dat;
    assign OUT_LAST  = beat_q.last;

endmodule

// File: tb/tb_regfile_dump_reader.sv
`timescale 1ns/1ps
// Scoreboard bench for regfile_dump_reader: expected beats queued at START, checked at each handshake.
module tb_regfile_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 32;
`ifdef REGDUMP_SKIP_ZERO_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NBEATS   = N - FIRST;
    localparam int DONE_CYC = 2 * NBEATS + 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic          OUT_READY = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] RA;
    logic [DW-1:0] RD;
    logic          OUT_VALID;
    logic [AW-1:0] OUT_ADDR;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_LAST;

    logic [DW-1:0] rf [N];
    assign RD = rf[RA];

    always #5 CLK = ~CLK;

    regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(BUSY), .DONE(DONE),
        .RA(RA), .RD(RD), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_ADDR(OUT_ADDR), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q [$];
    exp_t          mon_e;
    exp_t          held;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] seen_data [N];
    int            checks = 0;
    int            errors = 0;
    int            beats_seen = 0;
    int            done_cnt = 0;

    // Scoreboard: compare every accepted beat and verify stalled beats do not move.
    always @(negedge CLK) begin
        if (!RST_N) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                checks++;
                if (OUT_VALID !== 1'b1 || {OUT_ADDR, OUT_DATA, OUT_LAST} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b addr=%0d data=%h last=%b, required valid=1 addr=%0d data=%h last=%b",
                             OUT_VALID, OUT_ADDR, OUT_DATA, OUT_LAST, held.addr, held.data, held.last);
                end
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got addr=%0d data=%h, required no beat", OUT_ADDR, OUT_DATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({OUT_ADDR, OUT_DATA, OUT_LAST} !== mon_e) begin
                        errors++;
                        $display("FAIL beat: got addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                                 OUT_ADDR, OUT_DATA, OUT_LAST, mon_e.addr, mon_e.data, mon_e.last);
                    end
                    seen_data[OUT_ADDR] = OUT_DATA;
                    beats_seen++;
                end
            end
            hold_pend = (OUT_VALID === 1'b1) && (OUT_READY !== 1'b1);
            held      = {OUT_ADDR, OUT_DATA, OUT_LAST};
            if (DONE === 1'b1) done_cnt++;
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        beats_seen = 0;
        done_cnt   = 0;
    endtask

    task automatic push_dump();
        for (int a = FIRST; a < N; a++) begin
            exp_t t;
            t.addr = AW'(a);
            t.data = rf[a];
            t.last = (a == N - 1);
            exp_q.push_back(t);
        end
    endtask

    // Returns just after edge N, the edge that samples START.
    task automatic start_pulse();
        @(posedge CLK);
        #1 START = 1'b1;
        push_dump();
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW+AW+DW+4-1:0] outs;
        RST_N = 1'b0;
        START = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) @(negedge CLK);
        outs = {BUSY, DONE, OUT_VALID, OUT_LAST, RA, OUT_ADDR, OUT_DATA};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h, required 0", outs);
        end
        RST_N = 1'b1;
        clear_sb();
        OUT_READY = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            checks++;
            if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: cycle %0d got valid=%b busy=%b done=%b, required 0 0 0", c, OUT_VALID, BUSY, DONE);
            end
        end
    endtask

    task automatic test_full_dump();
        int done_at = 0;
        clear_sb();
        OUT_READY = 1'b1;
        start_pulse();
        for (int c = 1; c <= 4 * N + 20 && done_at == 0; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                checks++;
                if (OUT_VALID !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_cycle_valid: got %b, required 0", OUT_VALID);
                end
            end
            if (c == 2) begin
                checks++;
                if (OUT_VALID !== 1'b1 || BUSY !== 1'b1 || OUT_ADDR !== AW'(FIRST)) begin
                    errors++;
                    $display("FAIL first_beat: got valid=%b busy=%b addr=%0d, required 1 1 %0d", OUT_VALID, BUSY, OUT_ADDR, FIRST);
                end
            end
            if (DONE === 1'b1) begin
                done_at = c;
                checks++;
                if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
                    errors++;
                    $display("FAIL done_cycle_idle: got busy=%b valid=%b, required 0 0", BUSY, OUT_VALID);
                end
            end
        end
        checks++;
        if (done_at != DONE_CYC) begin
            errors++;
            $display("FAIL done_timing: got cycle %0d, required %0d", done_at, DONE_CYC);
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got %b, required 0", DONE);
        end
        checks++;
        if (beats_seen != NBEATS || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL full_dump_count: got beats=%0d left=%0d dones=%0d, required %0d 0 1", beats_seen, exp_q.size(), done_cnt, NBEATS);
        end
    endtask

    task automatic test_backpressure();
        logic got_done = 1'b0;
        clear_sb();
        start_pulse();
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(posedge CLK);
            #1 OUT_READY = ($urandom_range(0, 99) >= 30);
            @(negedge CLK);
            if (DONE === 1'b1) got_done = 1'b1;
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        checks++;
        if (!got_done || beats_seen != NBEATS || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL backpressure: got done=%b beats=%0d left=%0d dones=%0d, required 1 %0d 0 1", got_done, beats_seen, exp_q.size(), done_cnt, NBEATS);
        end
    endtask

    task automatic test_start_while_busy();
        logic got_done = 1'b0;
        logic pulsed = 1'b0;
        clear_sb();
        OUT_READY = 1'b1;
        start_pulse();
        for (int c = 0; c < 4 * N + 20 && !got_done; c++) begin
            @(posedge CLK);
            #1;
            if (beats_seen == 10 && !pulsed) begin
                START = 1'b1;
                pulsed = 1'b1;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            if (DONE === 1'b1) got_done = 1'b1;
        end
        START = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            checks++;
            if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL restart_ignored: got valid=%b busy=%b, required 0 0", OUT_VALID, BUSY);
            end
        end
        checks++;
        if (!got_done || beats_seen != NBEATS || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL start_while_busy: got done=%b beats=%0d left=%0d dones=%0d, required 1 %0d 0 1", got_done, beats_seen, exp_q.size(), done_cnt, NBEATS);
        end
    endtask

    task automatic test_reset_mid_dump();
        logic hit = 1'b0;
        logic got_done = 1'b0;
        logic [AW+AW+DW+4-1:0] outs;
        clear_sb();
        OUT_READY = 1'b1;
        start_pulse();
        for (int c = 0; c < 4 * N + 20 && !hit; c++) begin
            @(posedge CLK);
            #1;
            if (beats_seen == 17) begin
                RST_N = 1'b0;
                hit = 1'b1;
                #1;
                outs = {BUSY, DONE, OUT_VALID, OUT_LAST, RA, OUT_ADDR, OUT_DATA};
                checks++;
                if (outs !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_dump_values: got %h, required 0", outs);
                end
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_dump_reach: got beats=%0d, required 17", beats_seen);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        clear_sb();
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            checks++;
            if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL after_reset_quiet: got valid=%b busy=%b done=%b, required 0 0 0", OUT_VALID, BUSY, DONE);
            end
        end
        start_pulse();
        for (int c = 0; c < 4 * N + 20 && !got_done; c++) begin
            @(negedge CLK);
            if (DONE === 1'b1) got_done = 1'b1;
        end
        @(negedge CLK);
        checks++;
        if (!got_done || beats_seen != NBEATS || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL dump_after_reset: got done=%b beats=%0d left=%0d dones=%0d, required 1 %0d 0 1", got_done, beats_seen, exp_q.size(), done_cnt, NBEATS);
        end
    endtask

    task automatic test_write_during_dump();
        logic got_done = 1'b0;
        logic wrote = 1'b0;
        logic [DW-1:0] saved;
        saved = rf[20];
        clear_sb();
        OUT_READY = 1'b1;
        start_pulse();
        for (int c = 0; c < 4 * N + 20 && !got_done; c++) begin
            @(posedge CLK);
            #1;
            if (beats_seen == 5 && !wrote) begin
                rf[20] = 32'hDEAD_BEEF;
                foreach (exp_q[i]) begin
                    if (exp_q[i].addr == AW'(20)) begin
                        exp_t t;
                        t = exp_q[i];
                        t.data = 32'hDEAD_BEEF;
                        exp_q[i] = t;
                    end
                end
                wrote = 1'b1;
            end
            @(negedge CLK);
            if (DONE === 1'b1) got_done = 1'b1;
        end
        checks++;
        if (seen_data[20] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_visible: got %h, required deadbeef", seen_data[20]);
        end
        checks++;
        if (!got_done || beats_seen != NBEATS || exp_q.size() != 0) begin
            errors++;
            $display("FAIL write_dump_count: got done=%b beats=%0d left=%0d, required 1 %0d 0", got_done, beats_seen, exp_q.size(), NBEATS);
        end
        rf[20] = saved;
    endtask

    initial begin
        for (int i = 0; i < N; i++) rf[i] = 32'hA5A5_0000 + 32'(i);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
        test_write_during_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential reader that walks every entry of the 32x32 general-purpose register file through one asynchronous read port and streams each word out over a valid/ready interface. It sits beside the CPU datapath and is the debug/trace-side consumer of the register file. A single START pulse produces one complete, address-ordered dump, tagged with register numbers, followed by a DONE pulse.

## Interface
- ADDR_WIDTH, 5, register address width; dump covers 2**ADDR_WIDTH entries
- DATA_WIDTH, 32, register word width

- CLK  input  1  rising-edge clock
- RST_N  input  1  reset, asynchronous and active-low
- START  input  1  request a dump; sampled only in IDLE
- BUSY  output  1  high from the cycle after START acceptance until DONE
- DONE  output  1  one-cycle pulse after the last beat is accepted
- RA  output  ADDR_WIDTH  read address to register file port
- RD  input  DATA_WIDTH  combinational read data for RA
- OUT_VALID  output  1  stream beat valid
- OUT_READY  input  1  downstream accepts beat
- OUT_ADDR  output  ADDR_WIDTH  register number of current beat
- OUT_DATA  output  DATA_WIDTH  register contents of current beat
- OUT_LAST  output  1  high on the final beat of a dump

## Operation
- FSM states: IDLE, FETCH, SEND.
- IDLE: BUSY=0, OUT_VALID=0. START=1 -> counter loaded with first address (0), go FETCH. START in any other state ignored.
- FETCH: RA=counter; RD captured into OUT_DATA, counter into OUT_ADDR; OUT_LAST set if counter = last address (2**ADDR_WIDTH-1); go SEND.
- SEND: OUT_VALID=1; OUT_ADDR/OUT_DATA/OUT_LAST held stable until accepted. On OUT_VALID&&OUT_READY: if OUT_LAST -> DONE pulse, go IDLE; else counter+1, go FETCH.
- RA outside FETCH held at counter value (no other significance).
- Each word is sampled in its own FETCH cycle; writes to the register file during a dump are visible for entries not yet fetched. No whole-file snapshot coherence.
- Counter is ADDR_WIDTH bits; never wraps within a dump (terminates on OUT_LAST).
- OUT_VALID never deasserts without a handshake (AXI-stream style rule).

## Timing
- Reset values: BUSY=0, DONE=0, OUT_VALID=0, OUT_LAST=0, OUT_ADDR=0, OUT_DATA=0, RA=0; state IDLE.
- START at edge N -> FETCH during cycle N+1, OUT_VALID=1 and BUSY=1 from cycle N+2.
- Throughput: with OUT_READY held high, one beat every 2 cycles; full default dump = 64 cycles from START to final handshake, DONE in the following cycle.
- DONE asserted the cycle after the last handshake, in IDLE; BUSY=0 in that same cycle; a START sampled in that cycle is accepted.
- Backpressure: OUT_READY low stalls in SEND indefinitely, all outputs frozen.
- RST_N low mid-dump: immediate return to reset values; no DONE; partial dump discarded.

## Configuration
- REGDUMP_SKIP_ZERO_EN defined: register 0 (hardwired zero) is not emitted; START loads counter with 1; default dump = 31 beats, 62 cycles to final handshake.
- Not defined: all 2**ADDR_WIDTH entries emitted starting at address 0.

## Test plan
- Reset then idle: RST_N low 3 cycles -> all outputs 0; START never pulsed -> OUT_VALID stays 0 for 100 cycles.
- Full dump, OUT_READY=1: file preloaded reg[i]=0xA5A50000+i -> 32 beats, OUT_ADDR 0..31, OUT_DATA matches, OUT_LAST only on addr 31, DONE one cycle after beat 31 (64+1 cycles after START).
- Backpressure: OUT_READY random 30% -> data/addr stable while stalled, no beat lost or duplicated, order 0..31.
- START while BUSY pulsed at beat 10 -> ignored; exactly 32 beats, single DONE.
- Reset mid-dump at beat 17 -> OUT_VALID/BUSY 0 immediately, no DONE; next START yields full dump from addr 0.
- With REGDUMP_SKIP_ZERO_EN: first beat OUT_ADDR=1, 31 beats total, OUT_LAST on addr 31; write reg[20]=0xDEADBEEF during beat 5 -> beat 20 carries 0xDEADBEEF.
